// File: rtl/alu_pkg.sv
// Shared ALU definitions: command encoding, datapath width and the layout of
// a buffered result entry.
package alu_pkg;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_XOR  = 3'd2,
        CMD_SLT  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } alu_cmd_e;

    localparam int unsigned ALU_WIDTH  = 32;
    localparam int unsigned ALU_CMD_W  = 3;
    // Non-result bits of an entry: command, carry, overflow, zero.
    localparam int unsigned ALU_META_W = ALU_CMD_W + 3;

    typedef struct packed {
        alu_cmd_e               command;
        logic [ALU_WIDTH-1:0]   result;
        logic                   carry;
        logic                   overflow;
        logic                   zero;
    } alu_entry_t;

    localparam int unsigned ALU_ENTRY_W = $bits(alu_entry_t);

    // Only the adder/subtractor produce meaningful carry and overflow.
    function automatic logic alu_has_flags(input logic [ALU_CMD_W-1:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB);
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Generic WIDTH x DEPTH synchronous FIFO; output is the storage word at the
// read pointer, so the head entry is visible without a read strobe.
module alu_result_fifo #(
    parameter int unsigned WIDTH = 38,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Registered ALU output stage: zero detect and flag masking at push, a small
// result FIFO, sticky overflow and a completed-operation counter.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_command,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carryout,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_command,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carryout,
    output logic             out_overflow,
    output logic             out_zero,
    input  logic             clear_sticky,
    output logic             sticky_overflow,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned EW = WIDTH + ALU_META_W;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_flags_ok;
    logic          w_carry_m;
    logic          w_ovf_m;
    logic          w_zero;
    logic [EW-1:0] w_wr_entry;
    logic [EW-1:0] w_rd_entry;

    logic             r_sticky;
    logic [CNT_W-1:0] r_op_count;

    // Status comes purely from FIFO occupancy, so out_ready never reaches in_ready.
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_flags_ok = alu_has_flags(in_command);
    assign w_carry_m  = in_carryout && w_flags_ok;
    assign w_ovf_m    = in_overflow && w_flags_ok;
    assign w_zero     = ~|in_result;
    assign w_wr_entry = {in_command, in_result, w_carry_m, w_ovf_m, w_zero};

    alu_result_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_wr_entry),
        .i_pop   (w_pop),
        .o_data  (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_command  = w_rd_entry[EW-1 -: ALU_CMD_W];
    assign out_result   = w_rd_entry[3 +: WIDTH];
    assign out_carryout = w_rd_entry[2];
    assign out_overflow = w_rd_entry[1];
    assign out_zero     = w_rd_entry[0];

    // A set in the same cycle as clear_sticky takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_push && w_ovf_m) begin
            r_sticky <= 1'b1;
        end else if (clear_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_pop) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign sticky_overflow = r_sticky;
    assign op_count        = r_op_count;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed self-checking bench for alu_result_buffer (WIDTH=32, DEPTH=2, CNT_W=16).
module tb_alu_result_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_command;
    logic [31:0] in_result;
    logic        in_carryout;
    logic        in_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_command;
    logic [31:0] out_result;
    logic        out_carryout;
    logic        out_overflow;
    logic        out_zero;
    logic        clear_sticky;
    logic        sticky_overflow;
    logic [15:0] op_count;

    int unsigned total;
    int unsigned bad;
    int unsigned exp_cnt;

    alu_result_buffer #(
        .WIDTH (32),
        .DEPTH (2),
        .CNT_W (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_command      (in_command),
        .in_result       (in_result),
        .in_carryout     (in_carryout),
        .in_overflow     (in_overflow),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_command     (out_command),
        .out_result      (out_result),
        .out_carryout    (out_carryout),
        .out_overflow    (out_overflow),
        .out_zero        (out_zero),
        .clear_sticky    (clear_sticky),
        .sticky_overflow (sticky_overflow),
        .op_count        (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [2:0] cmd, input logic [31:0] res,
                         input logic c, input logic o);
        in_valid    = v;
        in_command  = cmd;
        in_result   = res;
        in_carryout = c;
        in_overflow = o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        out_ready    = 1'b0;
        clear_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (op_count !== 16'd0) begin bad++; $display("FAIL reset_op_count got=%0d want=0", op_count); end
        total++; if (sticky_overflow !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b want=0", sticky_overflow); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_out_result got=%h want=0", out_result); end
    endtask

    task automatic test_add_zero();
        out_ready = 1'b1;
        drive(1'b1, 3'd0, 32'h0000_0000, 1'b1, 1'b0);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_no_fallthrough got=%b want=0", out_valid); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_out_valid got=%b want=1", out_valid); end
        total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL add_zero got=%b want=1", out_zero); end
        total++; if (out_carryout !== 1'b1) begin bad++; $display("FAIL add_carry got=%b want=1", out_carryout); end
        total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL add_ovf got=%b want=0", out_overflow); end
        total++; if (out_command !== 3'd0) begin bad++; $display("FAIL add_cmd got=%0d want=0", out_command); end
        tick();
        exp_cnt = 1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drained got=%b want=0", out_valid); end
        total++; if (op_count !== 16'(exp_cnt)) begin bad++; $display("FAIL add_op_count got=%0d want=%0d", op_count, exp_cnt); end
    endtask

    task automatic test_mask_xor();
        out_ready = 1'b1;
        drive(1'b1, 3'd2, 32'h0000_0005, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        total++; if (out_result !== 32'h5) begin bad++; $display("FAIL xor_result got=%h want=5", out_result); end
        total++; if (out_command !== 3'd2) begin bad++; $display("FAIL xor_cmd got=%0d want=2", out_command); end
        total++; if (out_carryout !== 1'b0) begin bad++; $display("FAIL xor_carry_mask got=%b want=0", out_carryout); end
        total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL xor_ovf_mask got=%b want=0", out_overflow); end
        total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL xor_zero got=%b want=0", out_zero); end
        total++; if (sticky_overflow !== 1'b0) begin bad++; $display("FAIL xor_sticky got=%b want=0", sticky_overflow); end
        tick();
        exp_cnt += 1;
        total++; if (op_count !== 16'(exp_cnt)) begin bad++; $display("FAIL xor_op_count got=%0d want=%0d", op_count, exp_cnt); end
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'h11, 1'b0, 1'b0);
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready1 got=%b want=1", in_ready); end
        drive(1'b1, 3'd7, 32'h22, 1'b0, 1'b0);
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%b want=0", in_ready); end
        // Blocked overflowing push must leave no trace.
        drive(1'b1, 3'd1, 32'h33, 1'b0, 1'b1);
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_still_full got=%b want=0", in_ready); end
        total++; if (sticky_overflow !== 1'b0) begin bad++; $display("FAIL fill_blocked_sticky got=%b want=0", sticky_overflow); end
        total++; if (out_result !== 32'h11) begin bad++; $display("FAIL fill_hold got=%h want=11", out_result); end
        drive(1'b1, 3'd4, 32'h44, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        total++; if (out_result !== 32'h22) begin bad++; $display("FAIL drain_second got=%h want=22", out_result); end
        total++; if (out_command !== 3'd7) begin bad++; $display("FAIL drain_second_cmd got=%0d want=7", out_command); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_result !== 32'h44) begin bad++; $display("FAIL drain_third got=%h want=44", out_result); end
        total++; if (out_command !== 3'd4) begin bad++; $display("FAIL drain_third_cmd got=%0d want=4", out_command); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_third_valid got=%b want=1", out_valid); end
        tick();
        exp_cnt += 3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", out_valid); end
        total++; if (op_count !== 16'(exp_cnt)) begin bad++; $display("FAIL drain_op_count got=%0d want=%0d", op_count, exp_cnt); end
    endtask

    task automatic test_sticky();
        out_ready = 1'b1;
        drive(1'b1, 3'd1, 32'h8000_0000, 1'b1, 1'b1);
        tick();
        total++; if (sticky_overflow !== 1'b1) begin bad++; $display("FAIL sticky_set got=%b want=1", sticky_overflow); end
        total++; if (out_overflow !== 1'b1) begin bad++; $display("FAIL sub_ovf got=%b want=1", out_overflow); end
        total++; if (out_carryout !== 1'b1) begin bad++; $display("FAIL sub_carry got=%b want=1", out_carryout); end
        drive(1'b1, 3'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        clear_sticky = 1'b1;
        tick();
        total++; if (sticky_overflow !== 1'b1) begin bad++; $display("FAIL sticky_set_wins got=%b want=1", sticky_overflow); end
        in_valid = 1'b0;
        tick();
        clear_sticky = 1'b0;
        exp_cnt += 2;
        total++; if (sticky_overflow !== 1'b0) begin bad++; $display("FAIL sticky_clear got=%b want=0", sticky_overflow); end
        total++; if (op_count !== 16'(exp_cnt)) begin bad++; $display("FAIL sticky_op_count got=%0d want=%0d", op_count, exp_cnt); end
    endtask

    task automatic test_wrap();
        int unsigned n;
        n = 65535 - exp_cnt;
        out_ready = 1'b1;
        drive(1'b1, 3'd7, 32'hA5A5_0000, 1'b0, 1'b0);
        repeat (n) @(posedge clk);
        #1 in_valid = 1'b0;
        tick();
        exp_cnt = 65535;
        total++; if (op_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h want=ffff", op_count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_drained got=%b want=0", out_valid); end
        drive(1'b1, 3'd0, 32'h1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h want=0000", op_count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 3'd3, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd6, 32'hFFFF_FFFE, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_prefill_valid got=%b want=1", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_prefill_full got=%b want=0", in_ready); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", in_ready); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL mid_rst_result got=%h want=0", out_result); end
        total++; if (out_command !== 3'd0) begin bad++; $display("FAIL mid_rst_cmd got=%0d want=0", out_command); end
        #2 rst_n = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_after_rst_valid got=%b want=0", out_valid); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_cnt = 0;
        test_reset();
        test_add_zero();
        test_mask_xor();
        test_fill_drain();
        test_sticky();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered output stage for the 32-bit ALU: captures each ALU result together with its command, carry-out and overflow, computes the zero flag (the adder ties `zero` low), and holds results in a small FIFO behind a valid/ready handshake for the writeback consumer. It also maintains a sticky overflow flag and a completed-operation counter. It sits directly downstream of the ALU result mux.

## Interface
Parameters:
- `WIDTH`, 32: result width in bits.
- `DEPTH`, 2: FIFO entries; power of two, ≥ 2.
- `CNT_W`, 16: width of `op_count`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ALU presents a result.
- `in_ready`  out  1  buffer can accept an entry.
- `in_command`  in  3  ALU command that produced the result.
- `in_result`  in  WIDTH  ALU result.
- `in_carryout`  in  1  ALU carry-out.
- `in_overflow`  in  1  ALU overflow.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_command`  out  3  head entry command.
- `out_result`  out  WIDTH  head entry result.
- `out_carryout`  out  1  head entry carry-out, masked.
- `out_overflow`  out  1  head entry overflow, masked.
- `out_zero`  out  1  head entry result == 0.
- `clear_sticky`  in  1  synchronous clear of `sticky_overflow`.
- `sticky_overflow`  out  1  set when any accepted entry carries overflow.
- `op_count`  out  CNT_W  number of entries popped since reset; wraps.

## Operation
- Command encoding: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
- Push:
  - Occurs when `in_valid && in_ready`.
  - The stored entry is {command, result, carry, overflow, zero}.
  - `zero` is computed at push time as the NOR of all `in_result` bits.
- Masking, applied at push: carry and overflow are stored as 0 unless the command is ADD or SUB.
- Pop: occurs when `out_valid && out_ready`, and advances the read pointer.
- Status:
  - `in_ready = (count != DEPTH)`, registered state only.
  - There is no combinational path from `out_ready` to `in_ready`.
  - `out_valid = (count != 0)`.
- Pointers are log2(DEPTH) bits and wrap naturally.
- `count` is log2(DEPTH)+1 bits.
- Simultaneous push and pop:
  - When not empty and not full, both take effect and `count` is unchanged.
  - When empty, only the push occurs, because `out_valid` is 0.
  - When full, only the pop occurs, because `in_ready` is 0.
- `sticky_overflow` is set on a push whose masked overflow is 1. If set and `clear_sticky` occur in the same cycle, set wins.
- `op_count` increments by 1 on each pop, and wraps from all-ones to 0.
- Outputs hold stable while `out_valid && !out_ready`.
- Out-of-protocol inputs (`in_valid` with `in_ready` low) are ignored and have no side effects.

## Timing
- Latency: an entry pushed at edge N is visible on `out_*` with `out_valid=1` after edge N; there is no fall-through in the same cycle.
- Throughput: one entry per cycle when `out_ready` is held high.
- Reset values:
  - `out_valid=0` and `in_ready=1`.
  - `sticky_overflow=0` and `op_count=0`.
  - Pointers and `count` are 0.
  - `out_*` data fields are 0.
- Reset mid-operation: all entries are discarded immediately (asynchronous), and outputs take their reset values.
- Data outputs are driven from the storage array indexed by the read pointer.

## Structure
- Shared package `alu_pkg`:
  - 3-bit command constants (ADD…OR).
  - `ALU_WIDTH=32`.
  - An entry struct/width constant.
- Sub-module `alu_result_fifo`: generic WIDTH×DEPTH synchronous FIFO holding the packed entry, with push/pop/full/empty.
- The top level contains zero detection, masking, the sticky flag and the counter.

## Test plan
- Reset then idle: `out_valid=0`, `in_ready=1`, `op_count=0`, `sticky_overflow=0`.
- Push ADD with result 0x00000000, carry 1, overflow 0, `out_ready=1`. Next cycle: `out_zero=1`, `out_carryout=1`; after pop, `op_count=1`.
- Push XOR with result 0x00000005, carry 1, overflow 1. Output shows `out_carryout=0`, `out_overflow=0`, `out_zero=0`; `sticky_overflow` stays 0.
- Fill and drain:
  - Hold `out_ready=0` and push 3 entries. Only 2 are accepted, and `in_ready=0` after the second.
  - Release `out_ready`. Entries pop in order, then the third is accepted.
- Push SUB with overflow 1: `sticky_overflow=1`. Assert `clear_sticky` in the same cycle as another overflowing SUB push: the flag stays 1. `clear_sticky` alone: the flag goes to 0.
- Wrap and reset:
  - Preload `op_count` by 65535 pops; the next pop gives 0.
  - Assert `rst_n=0` with 2 entries buffered: `out_valid` drops immediately and `in_ready=1`.
